// File: rtl/alu_share_arbiter.sv
// Purpose : shares one external combinational ALU between two requesters, round-robin on ties.
// Latency : a request accepted in cycle N shows up in that requester's result buffer in cycle N+1.
// Backpressure: a full result buffer that is not being drained makes its requester ineligible for grant.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid_i / req_ready_i request handshake per requester (ready is the grant)
//   req_op1_i, req_op2_i, req_ctrl_i  operands and ALU control, held stable while valid
//   rsp_valid_i / rsp_ready_i result handshake per requester
//   rsp_data_i, rsp_zero_i    buffered ALU result and Zero flag
//   alu_data1_o, alu_data2_o, alu_ctrl_o  drive the shared ALU
//   alu_data_i, alu_zero_i    sampled from the shared ALU
//   conflict_cnt              saturating count of cycles with both requesters eligible
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_op1_0,
  input  logic [WIDTH-1:0] req_op2_0,
  input  logic [3:0]       req_ctrl_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_op1_1,
  input  logic [WIDTH-1:0] req_op2_1,
  input  logic [3:0]       req_ctrl_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_data_0,
  output logic             rsp_zero_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data_1,
  output logic             rsp_zero_1,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  localparam logic [3:0] CTRL_ADD = 4'b0010;

  buf_state_t buf_state_0;
  buf_state_t buf_state_1;
  logic       last_grant;
  logic       elig_0;
  logic       elig_1;
  logic       grant_0;
  logic       grant_1;
  logic       xfer_0;
  logic       xfer_1;

  // A requester may issue when its buffer is empty or is being drained this
  // same cycle, which is what allows one op per cycle per requester.
  assign elig_0 = req_valid_0 && ((buf_state_0 == BUF_EMPTY) || rsp_ready_0);
  assign elig_1 = req_valid_1 && ((buf_state_1 == BUF_EMPTY) || rsp_ready_1);

  // On a tie the requester that was not granted last wins.
  assign grant_0 = elig_0 && (!elig_1 || last_grant);
  assign grant_1 = elig_1 && (!elig_0 || !last_grant);

  assign req_ready_0 = grant_0 && !rst;
  assign req_ready_1 = grant_1 && !rst;

  assign xfer_0 = req_valid_0 && req_ready_0;
  assign xfer_1 = req_valid_1 && req_ready_1;

  assign rsp_valid_0 = (buf_state_0 == BUF_FULL);
  assign rsp_valid_1 = (buf_state_1 == BUF_FULL);

  // Idle ALU sees a harmless ADD of zeros.
  always_comb begin
    alu_data1_o = '0;
    alu_data2_o = '0;
    alu_ctrl_o  = CTRL_ADD;
    if (grant_0) begin
      alu_data1_o = req_op1_0;
      alu_data2_o = req_op2_0;
      alu_ctrl_o  = req_ctrl_0;
    end else if (grant_1) begin
      alu_data1_o = req_op1_1;
      alu_data2_o = req_op2_1;
      alu_ctrl_o  = req_ctrl_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state_0  <= BUF_EMPTY;
      buf_state_1  <= BUF_EMPTY;
      rsp_data_0   <= '0;
      rsp_data_1   <= '0;
      rsp_zero_0   <= 1'b0;
      rsp_zero_1   <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      // Buffer 0: a reload while full takes priority over the drain.
      if (xfer_0) begin
        buf_state_0 <= BUF_FULL;
        rsp_data_0  <= alu_data_i;
        rsp_zero_0  <= alu_zero_i;
      end else if (rsp_ready_0) begin
        buf_state_0 <= BUF_EMPTY;
      end

      if (xfer_1) begin
        buf_state_1 <= BUF_FULL;
        rsp_data_1  <= alu_data_i;
        rsp_zero_1  <= alu_zero_i;
      end else if (rsp_ready_1) begin
        buf_state_1 <= BUF_EMPTY;
      end

      if (xfer_0) begin
        last_grant <= 1'b0;
      end else if (xfer_1) begin
        last_grant <= 1'b1;
      end

      if (elig_0 && elig_1 && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid_0, req_valid_1;
  logic             req_ready_0, req_ready_1;
  logic [WIDTH-1:0] req_op1_0, req_op2_0, req_op1_1, req_op2_1;
  logic [3:0]       req_ctrl_0, req_ctrl_1;
  logic             rsp_valid_0, rsp_valid_1;
  logic             rsp_ready_0, rsp_ready_1;
  logic [WIDTH-1:0] rsp_data_0, rsp_data_1;
  logic             rsp_zero_0, rsp_zero_1;
  logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [3:0]       alu_ctrl_o;
  logic             alu_zero_i;
  logic [CNT_W-1:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_op1_0(req_op1_0), .req_op2_0(req_op2_0), .req_ctrl_0(req_ctrl_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_op1_1(req_op1_1), .req_op2_1(req_op2_1), .req_ctrl_1(req_ctrl_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_data_0(rsp_data_0), .rsp_zero_0(rsp_zero_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_data_1(rsp_data_1), .rsp_zero_1(rsp_zero_1),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
    .conflict_cnt(conflict_cnt)
  );

  // External ALU behaviour, also used by the reference model.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd3:    r = a ^ b;
      4'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    r = a << b[4:0];
      4'd10:   r = a >> b[4:0];
      4'd11:   r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_data_i = alu_f(alu_data1_o, alu_data2_o, alu_ctrl_o);
  assign alu_zero_i = (alu_data_i == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (r == 0) begin
      req_valid_0 = v; req_op1_0 = a; req_op2_0 = b; req_ctrl_0 = c;
    end else begin
      req_valid_1 = v; req_op1_1 = a; req_op2_1 = b; req_ctrl_1 = c;
    end
  endtask

  task automatic set_idle();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd2);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd2);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] exp_d;
    logic        exp_z;
  } vec_t;

  vec_t vecs[11];

  // Random-test reference state
  logic        mv[2];
  logic [31:0] md[2];
  logic        mz[2];
  int          mlast;
  int          mcnt;
  logic        rv[2];
  logic [31:0] ra[2];
  logic [31:0] rb[2];
  logic [3:0]  rc[2];
  logic        rr[2];
  logic [3:0]  ctrl_list[9];

  initial begin
    int n0, n1;
    vecs[0]  = '{0, 32'd5,        32'd7,        4'd2,  32'd12,       1'b0};
    vecs[1]  = '{1, 32'd9,        32'd9,        4'd6,  32'd0,        1'b1};
    vecs[2]  = '{0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd0,  32'h00F000F0, 1'b0};
    vecs[3]  = '{1, 32'h000000F0, 32'h0000000F, 4'd1,  32'h000000FF, 1'b0};
    vecs[4]  = '{0, 32'hFFFF0000, 32'hFF00FF00, 4'd3,  32'h00FFFF00, 1'b0};
    vecs[5]  = '{1, 32'hFFFFFFFF, 32'd1,        4'd8,  32'd1,        1'b0};
    vecs[6]  = '{0, 32'd1,        32'hFFFFFFFF, 4'd8,  32'd0,        1'b1};
    vecs[7]  = '{1, 32'd1,        32'h00000024, 4'd9,  32'h00000010, 1'b0};
    vecs[8]  = '{0, 32'h80000000, 32'd4,        4'd10, 32'h08000000, 1'b0};
    vecs[9]  = '{1, 32'h80000000, 32'd4,        4'd11, 32'hF8000000, 1'b0};
    vecs[10] = '{0, 32'hFFFFFFFF, 32'd1,        4'd2,  32'd0,        1'b1};
    ctrl_list = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};

    // Reset state
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid_0 = 1'b1;
    #1;
    chk("rst_ready0", 32'(req_ready_0), 32'd0);
    chk("rst_rsp_valid0", 32'(rsp_valid_0), 32'd0);
    chk("rst_rsp_valid1", 32'(rsp_valid_1), 32'd0);
    chk("rst_rsp_data0", rsp_data_0, 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    req_valid_0 = 1'b0;
    #1;
    chk("idle_alu_ctrl", 32'(alu_ctrl_o), 32'd2);
    chk("idle_alu_data1", alu_data1_o, 32'd0);
    rst = 1'b0;

    // Single req0 ADD
    set_req(0, 1'b1, 32'd5, 32'd7, 4'd2);
    #1;
    chk("t1_ready0", 32'(req_ready_0), 32'd1);
    chk("t1_alu_data1", alu_data1_o, 32'd5);
    chk("t1_alu_data2", alu_data2_o, 32'd7);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd2);
    rsp_ready_0 = 1'b1;
    #1;
    chk("t1_rsp_valid0", 32'(rsp_valid_0), 32'd1);
    chk("t1_rsp_data0", rsp_data_0, 32'd12);
    chk("t1_rsp_zero0", 32'(rsp_zero_0), 32'd0);
    cyc();
    rsp_ready_0 = 1'b0;
    #1;
    chk("t1_drained", 32'(rsp_valid_0), 32'd0);

    // Table of single operations through alternating requesters
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].r, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      chk($sformatf("vec%0d_ready", i),
          32'((vecs[i].r == 0) ? req_ready_0 : req_ready_1), 32'd1);
      cyc();
      set_req(vecs[i].r, 1'b0, 32'd0, 32'd0, 4'd2);
      if (vecs[i].r == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
      #1;
      chk($sformatf("vec%0d_data", i),
          (vecs[i].r == 0) ? rsp_data_0 : rsp_data_1, vecs[i].exp_d);
      chk($sformatf("vec%0d_zero", i),
          32'((vecs[i].r == 0) ? rsp_zero_0 : rsp_zero_1), 32'(vecs[i].exp_z));
      cyc();
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b0;
    end

    // Tie from reset: req0 first, then req1
    do_reset();
    set_req(0, 1'b1, 32'd9, 32'd9, 4'd6);
    set_req(1, 1'b1, 32'hF0, 32'h0F, 4'd1);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    #1;
    chk("t2_ready0", 32'(req_ready_0), 32'd1);
    chk("t2_ready1", 32'(req_ready_1), 32'd0);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd2);
    #1;
    chk("t2_ready1_next", 32'(req_ready_1), 32'd1);
    chk("t2_rsp_data0", rsp_data_0, 32'd0);
    chk("t2_rsp_zero0", 32'(rsp_zero_0), 32'd1);
    cyc();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd2);
    #1;
    chk("t2_rsp_valid1", 32'(rsp_valid_1), 32'd1);
    chk("t2_rsp_data1", rsp_data_1, 32'hFF);
    chk("t2_cnt", 32'(conflict_cnt), 32'd1);

    // Continuous contention: strict alternation
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd2, 4'd2);
    set_req(1, 1'b1, 32'd3, 32'd4, 4'd2);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t3_grant0_c%0d", k), 32'(req_ready_0), 32'((k % 2) == 0));
      if (req_ready_0) n0++;
      if (req_ready_1) n1++;
      cyc();
    end
    set_idle();
    #1;
    chk("t3_n0", 32'(n0), 32'd4);
    chk("t3_n1", 32'(n1), 32'd4);
    chk("t3_cnt", 32'(conflict_cnt), 32'd8);

    // Back-to-back on req0 with backpressure
    do_reset();
    set_req(0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'd8);
    #1;
    chk("t4_ready_first", 32'(req_ready_0), 32'd1);
    cyc();
    set_req(0, 1'b1, 32'h80000000, 32'd4, 4'd11);
    #1;
    chk("t4_stall_a", 32'(req_ready_0), 32'd0);
    chk("t4_data_a", rsp_data_0, 32'd1);
    cyc();
    #1;
    chk("t4_stall_b", 32'(req_ready_0), 32'd0);
    chk("t4_held_b", rsp_data_0, 32'd1);
    rsp_ready_0 = 1'b1;
    #1;
    chk("t4_ready_drain", 32'(req_ready_0), 32'd1);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd2);
    rsp_ready_0 = 1'b0;
    #1;
    chk("t4_valid2", 32'(rsp_valid_0), 32'd1);
    chk("t4_data2", rsp_data_0, 32'hF8000000);
    cyc();
    #1;
    chk("t4_held2", rsp_data_0, 32'hF8000000);
    rsp_ready_0 = 1'b1;
    cyc();
    rsp_ready_0 = 1'b0;
    #1;
    chk("t4_drained", 32'(rsp_valid_0), 32'd0);

    // Reset while buffer 0 full and req1 pending
    do_reset();
    set_req(0, 1'b1, 32'd2, 32'd3, 4'd2);
    set_req(1, 1'b1, 32'd4, 32'd5, 4'd2);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd2);
    rst = 1'b1;
    #1;
    chk("t5_pre_valid0", 32'(rsp_valid_0), 32'd1);
    chk("t5_pre_cnt", 32'(conflict_cnt), 32'd1);
    chk("t5_rst_ready1", 32'(req_ready_1), 32'd0);
    cyc();
    rst = 1'b0;
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd2);
    #1;
    chk("t5_valid0", 32'(rsp_valid_0), 32'd0);
    chk("t5_valid1", 32'(rsp_valid_1), 32'd0);
    chk("t5_cnt", 32'(conflict_cnt), 32'd0);
    set_req(0, 1'b1, 32'd2, 32'd3, 4'd2);
    set_req(1, 1'b1, 32'd4, 32'd5, 4'd2);
    #1;
    chk("t5_tie_ready0", 32'(req_ready_0), 32'd1);
    chk("t5_tie_ready1", 32'(req_ready_1), 32'd0);
    cyc();
    set_idle();

    // Counter saturation with the 4-bit counter
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd2);
    set_req(1, 1'b1, 32'd2, 32'd2, 4'd2);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 14) begin
        #1;
        chk("t6_cnt_at15", 32'(conflict_cnt), 32'(CNT_MAX));
      end
    end
    set_idle();
    #1;
    chk("t6_cnt_sat", 32'(conflict_cnt), 32'(CNT_MAX));

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; md[i] = 32'd0; mz[i] = 1'b0; rv[i] = 1'b0;
      ra[i] = 32'd0; rb[i] = 32'd0; rc[i] = 4'd2; rr[i] = 1'b0;
    end
    mlast = 1;
    mcnt = 0;
    for (int cy = 0; cy < 600; cy++) begin
      logic el[2];
      logic go[2];
      logic do_rst;
      int   w;
      do_rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!rv[i]) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          ra[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
          rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
          rc[i] = ctrl_list[$urandom_range(0, 8)];
        end
        rr[i] = ($urandom_range(0, 1) == 1);
      end
      rst = do_rst;
      set_req(0, rv[0], ra[0], rb[0], rc[0]);
      set_req(1, rv[1], ra[1], rb[1], rc[1]);
      rsp_ready_0 = rr[0];
      rsp_ready_1 = rr[1];
      for (int i = 0; i < 2; i++) el[i] = rv[i] && (!mv[i] || rr[i]);
      if (el[0] && el[1]) w = (mlast == 1) ? 0 : 1;
      else if (el[0])     w = 0;
      else if (el[1])     w = 1;
      else                w = -1;
      if (do_rst) w = -1;
      go[0] = (w == 0);
      go[1] = (w == 1);
      #1;
      chk("rnd_ready0", 32'(req_ready_0), 32'(go[0]));
      chk("rnd_ready1", 32'(req_ready_1), 32'(go[1]));
      chk("rnd_valid0", 32'(rsp_valid_0), 32'(mv[0]));
      chk("rnd_valid1", 32'(rsp_valid_1), 32'(mv[1]));
      chk("rnd_data0", rsp_data_0, md[0]);
      chk("rnd_data1", rsp_data_1, md[1]);
      chk("rnd_zero0", 32'(rsp_zero_0), 32'(mz[0]));
      chk("rnd_zero1", 32'(rsp_zero_1), 32'(mz[1]));
      chk("rnd_cnt", 32'(conflict_cnt), 32'(mcnt));
      if (w >= 0) chk("rnd_alu_data1", alu_data1_o, ra[w]);
      @(posedge clk);
      if (do_rst) begin
        for (int i = 0; i < 2; i++) begin
          mv[i] = 1'b0; md[i] = 32'd0; mz[i] = 1'b0;
        end
        mlast = 1;
        mcnt = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (go[i]) begin
            mv[i] = 1'b1;
            md[i] = alu_f(ra[i], rb[i], rc[i]);
            mz[i] = (md[i] == 32'd0);
            rv[i] = 1'b0;
          end else if (rr[i]) begin
            mv[i] = 1'b0;
          end
        end
        if (w >= 0) mlast = w;
        if (el[0] && el[1] && mcnt < CNT_MAX) mcnt++;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
